// File: rtl/ofm_reader.sv
// ofm_reader -- drains the OFM DPRAM (port B) after the systolic array
// finishes and streams it to the host as packed valid/ready beats.
//
// Build option: define OFM_READER_RELU_EN to clamp negative entries to zero
// before packing; when undefined, entries pass through bit-exact.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             one-cycle kick-off, ignored unless idle
//   base_addr, len    first DPRAM address and entry count, sampled on start
//   ofm_re_b          DPRAM read enable (data returns one cycle later)
//   ofm_addr_b        DPRAM read address, wraps modulo 2^ADDR_WIDTH
//   ofm_dout_b        DPRAM read data
//   m_valid/m_ready   beat handshake; m_data lane k = entry k of the beat
//   m_data, m_last    packed beat and final-beat marker
//   busy, done        transfer in progress / one-cycle completion pulse
module ofm_reader #(
   parameter int OFM_WIDTH  = 16,
   parameter int OUT_WIDTH  = 128,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  ofm_re_b,
   output logic [ADDR_WIDTH-1:0] ofm_addr_b,
   input  logic [OFM_WIDTH-1:0]  ofm_dout_b,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int PACK   = OUT_WIDTH / OFM_WIDTH;
   localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  re_q, re_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rd_left_q, rd_left_d;     // reads not yet issued
   logic [LANE_W-1:0]     nlane_q, nlane_d;         // lane of the next read
   logic [LANE_W-1:0]     cur_lane_q, cur_lane_d;   // lane of the read in flight now
   logic                  cur_last_q, cur_last_d;
   logic                  rvalid_q, rvalid_d;       // DRAM data present this cycle
   logic [LANE_W-1:0]     rlane_q, rlane_d;
   logic                  rlast_q, rlast_d;
   logic [OUT_WIDTH-1:0]  pack_q, pack_d;
   logic [1:0]            res_q, res_d;             // beats reserved and not yet popped
   logic [1:0]            cnt_q, cnt_d;             // FIFO occupancy
   logic [OUT_WIDTH-1:0]  head_data_q, head_data_d;
   logic                  head_last_q, head_last_d;
   logic [OUT_WIDTH-1:0]  tail_data_q, tail_data_d;
   logic                  tail_last_q, tail_last_d;
   logic                  mvalid_q, mvalid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  pop_s;
   logic                  push_s;
   logic                  reserve_s;
   logic                  issue_ok_s;
   logic [1:0]            res_after_pop_s;
   logic [OUT_WIDTH-1:0]  merged_s;

   function automatic logic [OFM_WIDTH-1:0] relu(input logic [OFM_WIDTH-1:0] v);
`ifdef OFM_READER_RELU_EN
      return v[OFM_WIDTH-1] ? {OFM_WIDTH{1'b0}} : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] l);
      return (l == LANE_W'(PACK-1)) ? {LANE_W{1'b0}} : l + LANE_W'(1);
   endfunction

   assign pop_s = mvalid_q & m_ready;

   // Pack returning data into lanes and run the 2-entry output FIFO (head = output regs).
   always_comb begin
      merged_s = pack_q;
      if (rvalid_q) begin
         for (int k = 0; k < PACK; k++) begin
            if (rlane_q == LANE_W'(k)) begin
               merged_s[k*OFM_WIDTH +: OFM_WIDTH] = relu(ofm_dout_b);
            end else begin
               merged_s[k*OFM_WIDTH +: OFM_WIDTH] = pack_q[k*OFM_WIDTH +: OFM_WIDTH];
            end
         end
      end else begin
         merged_s = pack_q;
      end
      push_s = rvalid_q && ((rlane_q == LANE_W'(PACK-1)) || rlast_q);
      // Clearing after each push keeps the unused lanes of a short beat at zero.
      pack_d = push_s ? {OUT_WIDTH{1'b0}} : merged_s;

      cnt_d       = cnt_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      case (cnt_q)
         2'd0: begin
            if (push_s) begin
               head_data_d = merged_s;
               head_last_d = rlast_q;
               cnt_d       = 2'd1;
            end else begin
               cnt_d = 2'd0;
            end
         end
         2'd1: begin
            case ({push_s, pop_s})
               2'b11: begin
                  head_data_d = merged_s;
                  head_last_d = rlast_q;
               end
               2'b10: begin
                  tail_data_d = merged_s;
                  tail_last_d = rlast_q;
                  cnt_d       = 2'd2;
               end
               2'b01: cnt_d = 2'd0;
               default: cnt_d = 2'd1;
            endcase
         end
         2'd2: begin
            if (pop_s) begin
               head_data_d = tail_data_q;
               head_last_d = tail_last_q;
               cnt_d       = 2'd1;
               if (push_s) begin
                  tail_data_d = merged_s;
                  tail_last_d = rlast_q;
                  cnt_d       = 2'd2;
               end else begin
                  cnt_d = 2'd1;
               end
            end else begin
               cnt_d = 2'd2;
            end
         end
         default: cnt_d = 2'd0;
      endcase
      mvalid_d = (cnt_d != 2'd0);
   end

   // Transfer sequencing, read issue and beat-slot accounting.
   always_comb begin
      state_d    = state_q;
      re_d       = 1'b0;
      addr_d     = addr_q;
      rd_left_d  = rd_left_q;
      nlane_d    = nlane_q;
      cur_lane_d = cur_lane_q;
      cur_last_d = 1'b0;
      reserve_s  = 1'b0;
      done_d     = 1'b0;

      // A beat claims one of the two FIFO slots when its first read issues;
      // the slot frees when the beat pops, so a same-cycle pop counts here and
      // reads stay back-to-back without back-pressure.
      res_after_pop_s = res_q - {1'b0, pop_s};
      issue_ok_s      = (nlane_q != {LANE_W{1'b0}}) || (res_after_pop_s < 2'd2);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != (ADDR_WIDTH+1)'(0)) begin
                  state_d    = S_FETCH;
                  re_d       = 1'b1;
                  addr_d     = base_addr;
                  rd_left_d  = len - (ADDR_WIDTH+1)'(1);
                  cur_lane_d = {LANE_W{1'b0}};
                  cur_last_d = (len == (ADDR_WIDTH+1)'(1));
                  nlane_d    = next_lane({LANE_W{1'b0}});
                  reserve_s  = 1'b1;
               end else begin
                  state_d = S_FIN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (rd_left_q == (ADDR_WIDTH+1)'(0)) begin
               state_d = S_DRAIN;
            end else if (issue_ok_s) begin
               re_d       = 1'b1;
               addr_d     = addr_q + ADDR_WIDTH'(1);
               rd_left_d  = rd_left_q - (ADDR_WIDTH+1)'(1);
               cur_lane_d = nlane_q;
               cur_last_d = (rd_left_q == (ADDR_WIDTH+1)'(1));
               nlane_d    = next_lane(nlane_q);
               reserve_s  = (nlane_q == {LANE_W{1'b0}});
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            // Finishing on the final pop makes done land one cycle after it.
            if ((cnt_d == 2'd0) && !rvalid_q && !re_q) begin
               state_d = S_FIN;
               done_d  = 1'b1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_FIN: begin
            // Entered with done already set after a transfer; for len=0 the
            // pulse is raised here, giving done two cycles after start.
            if (done_q) begin
               state_d = S_IDLE;
            end else begin
               done_d  = 1'b1;
               state_d = S_FIN;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case ({reserve_s, pop_s})
         2'b10:   res_d = res_q + 2'd1;
         2'b01:   res_d = res_q - 2'd1;
         default: res_d = res_q;
      endcase

      busy_d     = (state_d != S_IDLE) && !done_d;
      rvalid_d   = re_q;
      rlane_d    = cur_lane_q;
      rlast_d    = cur_last_q;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         re_q        <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         rd_left_q   <= {(ADDR_WIDTH+1){1'b0}};
         nlane_q     <= {LANE_W{1'b0}};
         cur_lane_q  <= {LANE_W{1'b0}};
         cur_last_q  <= 1'b0;
         rvalid_q    <= 1'b0;
         rlane_q     <= {LANE_W{1'b0}};
         rlast_q     <= 1'b0;
         pack_q      <= {OUT_WIDTH{1'b0}};
         res_q       <= 2'd0;
         cnt_q       <= 2'd0;
         head_data_q <= {OUT_WIDTH{1'b0}};
         head_last_q <= 1'b0;
         tail_data_q <= {OUT_WIDTH{1'b0}};
         tail_last_q <= 1'b0;
         mvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         re_q        <= re_d;
         addr_q      <= addr_d;
         rd_left_q   <= rd_left_d;
         nlane_q     <= nlane_d;
         cur_lane_q  <= cur_lane_d;
         cur_last_q  <= cur_last_d;
         rvalid_q    <= rvalid_d;
         rlane_q     <= rlane_d;
         rlast_q     <= rlast_d;
         pack_q      <= pack_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         mvalid_q    <= mvalid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ofm_re_b   = re_q;
   assign ofm_addr_b = addr_q;
   assign m_valid    = mvalid_q;
   assign m_data     = head_data_q;
   assign m_last     = head_last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_ofm_reader.sv
// Self-checking bench for ofm_reader: DPRAM model, beat-level reference
// model with a per-cycle compare process, plus directed timing checks.
module tb_ofm_reader;
   localparam int OFM_WIDTH  = 16;
   localparam int OUT_WIDTH  = 128;
   localparam int ADDR_WIDTH = 14;
   localparam int PACK       = OUT_WIDTH / OFM_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   len;
   logic                  ofm_re_b;
   logic [ADDR_WIDTH-1:0] ofm_addr_b;
   logic [OFM_WIDTH-1:0]  ofm_dout_b;
   logic                  m_valid;
   logic                  m_ready;
   logic [OUT_WIDTH-1:0]  m_data;
   logic                  m_last;
   logic                  busy;
   logic                  done;

   always #5 clk = ~clk;

   ofm_reader #(.OFM_WIDTH(OFM_WIDTH), .OUT_WIDTH(OUT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .ofm_re_b(ofm_re_b), .ofm_addr_b(ofm_addr_b), .ofm_dout_b(ofm_dout_b),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   // DPRAM port B: registered read, data one cycle after the enable
   logic [OFM_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
   always @(posedge clk) begin
      if (ofm_re_b) ofm_dout_b <= mem[ofm_addr_b];
   end

   typedef struct {
      logic [OUT_WIDTH-1:0] data;
      logic                 last;
   } beat_t;
   beat_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [OUT_WIDTH-1:0] act, input logic [OUT_WIDTH-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [OFM_WIDTH-1:0] ref_entry(input logic [OFM_WIDTH-1:0] v);
`ifdef OFM_READER_RELU_EN
      if ($signed(v) < 0) return 16'h0000;
`endif
      return v;
   endfunction

   // Reference: beat b carries entries b*PACK.. of the run, missing lanes are zero
   task automatic build_model(input logic [ADDR_WIDTH-1:0] b, input int l);
      int nb;
      beat_t bt;
      exp_q.delete();
      nb = (l + PACK - 1) / PACK;
      for (int i = 0; i < nb; i++) begin
         bt.data = '0;
         for (int k = 0; k < PACK; k++) begin
            int idx;
            idx = i * PACK + k;
            if (idx < l) bt.data[k*OFM_WIDTH +: OFM_WIDTH] = ref_entry(mem[(int'(b) + idx) % (1 << ADDR_WIDTH)]);
         end
         bt.last = (i == nb - 1);
         exp_q.push_back(bt);
      end
   endtask

   bit                    chk_en = 1'b0;
   logic [ADDR_WIDTH-1:0] exp_addr;
   int                    reads_issued;
   int                    beats_popped;
   int                    cur_len;

   // Per-cycle compare process
   initial begin
      logic                 stall_prev;
      logic                 last_hs_prev;
      logic [OUT_WIDTH-1:0] prev_data;
      logic                 prev_last;
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
      prev_data    = '0;
      prev_last    = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (ofm_re_b) begin
               chk("rd_addr", ofm_addr_b, exp_addr);
               exp_addr = exp_addr + 14'd1;
               reads_issued++;
               chk("rd_window", (reads_issued <= cur_len) && (reads_issued <= PACK * (beats_popped + 2)), 1'b1);
            end
            if (stall_prev) begin
               chk("hold_valid", m_valid, 1'b1);
               chk("hold_data", m_data, prev_data);
               chk("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", 1'b1, 1'b0);
               end else begin
                  chk("beat_data", m_data, exp_q[0].data);
                  chk("beat_last", m_last, exp_q[0].last);
                  void'(exp_q.pop_front());
                  beats_popped++;
               end
            end
            chk("done_pulse", done, last_hs_prev);
            stall_prev   = m_valid && !m_ready;
            prev_data    = m_data;
            prev_last    = m_last;
            last_hs_prev = m_valid && m_ready && m_last;
         end else begin
            stall_prev   = 1'b0;
            last_hs_prev = 1'b0;
         end
      end
   end

   // Runs one transfer; cycle numbers are counted from the start edge (cycle 1 = T+1)
   task automatic run_xfer(input logic [ADDR_WIDTH-1:0] b, input int l, input int mode,
                           output int t_valid, output int t_done, output int t_re_last, output int t_busy1);
      build_model(b, l);
      exp_addr     = b;
      reads_issued = 0;
      beats_popped = 0;
      cur_len      = l;
      t_valid      = -1;
      t_done       = -1;
      t_re_last    = -1;
      t_busy1      = 0;
      chk_en       = 1'b1;
      m_ready      = 1'b1;
      start        = 1'b1;
      base_addr    = b;
      len          = 15'(l);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         // mode 1: ready follows 1-0-0-1
         m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         @(negedge clk);
         if (cyc == 1) t_busy1 = int'(busy);
         if (m_valid && t_valid < 0) t_valid = cyc;
         if (ofm_re_b) t_re_last = cyc;
         if (done) begin
            t_done = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      chk("xfer_done_seen", (t_done >= 0), 1'b1);
      @(posedge clk); #1;
      chk_en  = 1'b0;
      m_ready = 1'b1;
      chk("beats_left", exp_q.size(), 0);
      chk("reads_total", reads_issued, l);
   endtask

   initial begin
      int tv, td, tr, tb1, bad;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      m_ready   = 1'b0;
      for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = i[15:0];

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_re", ofm_re_b, 1'b0);
      chk("rst_addr", ofm_addr_b, 14'd0);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_data", m_data, 128'd0);
      chk("rst_last", m_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // two full beats, free-running host
      build_model(14'd0, 16);
      chk("model_t1_b0", exp_q[0].data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      chk("model_t1_b1", exp_q[1].data, 128'h000F_000E_000D_000C_000B_000A_0009_0008);
      run_xfer(14'd0, 16, 0, tv, td, tr, tb1);
      chk("t1_busy_at_T1", tb1, 1);
      chk("t1_first_valid", tv, 10);
      chk("t1_last_read", tr, 16);
      chk("t1_done", td, 19);

      // address wrap with a short final beat
      build_model(14'd16380, 10);
      chk("model_t2_b0", exp_q[0].data, 128'h0003_0002_0001_0000_3FFF_3FFE_3FFD_3FFC);
      chk("model_t2_b1", exp_q[1].data, 128'h0000_0000_0000_0000_0000_0000_0005_0004);
      run_xfer(14'd16380, 10, 0, tv, td, tr, tb1);
      chk("t2_last_read", tr, 10);
      chk("t2_done", td, 13);

      // host back-pressure 1-0-0-1
      run_xfer(14'd0, 64, 1, tv, td, tr, tb1);

      // len=0, second start while busy is ignored
      start = 1'b1; len = 15'd0; base_addr = 14'd5;
      @(posedge clk); #1;
      start = 1'b1; len = 15'd16;
      @(negedge clk);
      chk("len0_busy_T1", busy, 1'b1);
      chk("len0_done_T1", done, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("len0_done_T2", done, 1'b1);
      chk("len0_busy_T2", busy, 1'b0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (ofm_re_b || m_valid || done || busy) bad++;
      end
      chk("len0_quiet", bad, 0);

      // reset mid-FETCH with one beat held
      @(posedge clk); #1;
      m_ready = 1'b0; start = 1'b1; base_addr = 14'd0; len = 15'd64;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      @(negedge clk);
      chk("pre_rst_valid", m_valid, 1'b1);
      chk("pre_rst_reading", ofm_re_b, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", m_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_re", ofm_re_b, 1'b0);
      chk("post_rst_data", m_data, 128'd0);
      @(posedge clk); #1;
      run_xfer(14'd40, 12, 0, tv, td, tr, tb1);

      // alternating -5 / +7 entries
      for (int i = 0; i < 8; i++) mem[i] = (i % 2 == 0) ? 16'hFFFB : 16'h0007;
      build_model(14'd0, 8);
`ifdef OFM_READER_RELU_EN
      chk("model_relu", exp_q[0].data, 128'h0007_0000_0007_0000_0007_0000_0007_0000);
`else
      chk("model_raw", exp_q[0].data, 128'h0007_FFFB_0007_FFFB_0007_FFFB_0007_FFFB);
`endif
      run_xfer(14'd0, 8, 0, tv, td, tr, tb1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ofm_reader.md
# ofm_reader

Drains the output-feature-map DPRAM after the systolic array signals completion and streams its contents to the host over a valid/ready beat interface. It sits beside the OFM buffer on its B port, in the opposite direction to the IFM and weight loaders. It packs several OFM entries per beat and tolerates arbitrary host back-pressure with a 2-beat output FIFO.

## Interface
- OFM_WIDTH, 16, bit width of one signed OFM entry in the DPRAM
- OUT_WIDTH, 128, beat width; PACK = OUT_WIDTH/OFM_WIDTH entries per beat (8 by default)
- ADDR_WIDTH, 14, DPRAM address width (covers 32*16*32 = 16384 entries)

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, normally driven from the array's done; ignored while busy
- base_addr  in  ADDR_WIDTH  first DPRAM address to read; sampled on start
- len  in  ADDR_WIDTH+1  number of entries to read; sampled on start
- ofm_re_b  out  1  DPRAM port-B read enable
- ofm_addr_b  out  ADDR_WIDTH  DPRAM port-B address
- ofm_dout_b  in  OFM_WIDTH  DPRAM read data; valid exactly 1 cycle after ofm_re_b
- m_valid  out  1  beat available
- m_ready  in  1  host accepts the beat
- m_data  out  OUT_WIDTH  packed beat; lane i holds bits [i*OFM_WIDTH +: OFM_WIDTH]
- m_last  out  1  marks the final beat of the transfer
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last beat handshakes

## Operation
- Reset values: ofm_re_b=0, ofm_addr_b=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. The FIFO, pack register and all counters clear.
- FSM states:
  - IDLE: start with len>0 goes to FETCH; start with len=0 goes to FIN.
  - FETCH: issues reads until len reads have been issued, then goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is outstanding, then goes to FIN.
  - FIN: asserts done for one cycle, then returns to IDLE.
- Read issue:
  - Address starts at base_addr and increments by 1 per issued read, wrapping modulo 2^ADDR_WIDTH.
  - A read is issued only while (FIFO occupancy + a partially or fully issued beat in assembly) < 2. With no back-pressure, reads are back-to-back.
- Packing:
  - Entry k of a beat (k = 0..PACK-1, ascending address) goes to lane k.
  - A beat is pushed to the FIFO when the data for lane PACK-1 returns, or when the data for the final entry returns.
  - A short final beat (len not a multiple of PACK) has its unused upper lanes zero. m_last=1 on that beat only.
- Output: m_valid reflects a non-empty FIFO. A beat pops when m_valid && m_ready. m_data and m_last hold stable while m_valid && !m_ready.
- A push and a pop in the same cycle are both permitted; occupancy is unchanged.
- start during busy: ignored, with no effect on the current transfer.
- rst mid-transfer: the next cycle is IDLE with all outputs at reset values and in-flight read data discarded.
- Total beats = ceil(len/PACK).

## Timing
- start sampled at edge T:
  - busy=1 and the first ofm_re_b (addr=base_addr) occur in cycle T+1.
  - Reads run in cycles T+1..T+PACK.
  - The first beat enters the FIFO at the end of cycle T+PACK+1.
  - m_valid=1 in cycle T+PACK+2.
- Sustained throughput with m_ready held high: one beat per PACK cycles. A read/data phase for beat n+1 overlaps the output of beat n.
- ofm_re_b drops in the cycle after the last read is issued.
- done pulses in the cycle after the m_last handshake. busy falls in the same cycle done rises.
- For len=0: done pulses at T+2, with no read and no beat.

## Configuration
- OFM_READER_RELU_EN defined: each entry is treated as signed. Negative values are replaced by 0 before packing; zero-padding lanes are unaffected.
- OFM_READER_RELU_EN undefined: entries pass through bit-exact.
- Latency and handshake timing are identical in both builds.

## Test plan
- DPRAM preloaded with addr[15:0] values, base=0, len=16, m_ready=1 → 2 beats. Beat0 lanes = 0..7, beat1 lanes = 8..15, m_last only on beat1. m_valid first at T+10, done at beat1 handshake +1.
- len=10, base=16380 → addresses 16380..16383 then 0..5 (wrap). Beat1 lanes 2..7 = 0, m_last=1.
- Same data as the first test, with m_ready toggling 1-0-0-1 for 64 entries → 8 beats, none lost or duplicated. ofm_re_b stalls while 2 beats are held, and m_data stays stable while stalled.
- Entries alternating -5 and +7 → with OFM_READER_RELU_EN the lanes read 0,7,0,7…; without it, 0xFFFB,7,….
- len=0 → done at T+2 with no ofm_re_b. A second start issued at T+1 is ignored.
- rst asserted mid-FETCH with 1 beat in the FIFO → next cycle m_valid=0, busy=0. A fresh start then completes normally with correct data.
